reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Multi-domain reset controller. Releases NUM_STAGES active-low reset outputs in fixed order (stage 0 first), with a programmable delay between releases.
- Release is gated on a filtered PLL-lock input. Re-sequences on lock loss or on a software reset request.
- Sits between the board reset button / PLL and the per-domain logic (SDRAM controller, CPU, peripherals).
- Replaces per-domain free-running power-on delay counters.

Parameters:
- NUM_STAGES, 3: number of reset outputs; legal range 1..8.
- CNT_W, 24: width of the shared delay counter.
- STAGE_DLY, 24'hFFFFFF: cycles between successive stage releases; legal range 1..2^CNT_W-1.
- LOCK_FILTER, 16: consecutive cycles iPLL_LOCKED must be high before sequencing starts; minimum 1.
- SW_HOLD, 256: cycles all outputs stay asserted after a software request; minimum 1.
- WDT_CYCLES, 24'hFFFFFF: watchdog timeout; used only with the watchdog macro.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous, active-low reset.
- iPLL_LOCKED  in  1  PLL lock; treated as synchronous to iCLK.
- iSW_RST_REQ  in  1  single-cycle software reset request.
- iWDT_KICK  in  1  watchdog kick pulse.
- oRESET  out  NUM_STAGES  per-domain resets; active-low; bit k = stage k.
- oREADY  out  1  high when all stages are released.
- oSTATE  out  2  encoded state for debug: 0 WAIT_LOCK, 1 STAGE, 2 RUN, 3 HOLD.
- oWDT_FIRED  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset (iRST low, asynchronous):
  - oRESET = all 0, oREADY = 0, oWDT_FIRED = 0.
  - State = WAIT_LOCK; counter = 0; stage index = 0.
  - Takes effect immediately, from any state, mid-sequence included.
- WAIT_LOCK:
  - Counter increments each cycle iPLL_LOCKED = 1.
  - Any cycle with iPLL_LOCKED = 0 clears the counter.
  - When counter = LOCK_FILTER-1 with lock still high: next edge enters STAGE, counter = 0, index = 0.
- STAGE:
  - Counter increments every cycle.
  - When counter = STAGE_DLY-1: next edge sets oRESET[index] = 1, clears counter, increments index.
  - Releasing index NUM_STAGES-1 enters RUN and sets oREADY = 1 on the same edge.
- Release timing: with lock held high from the first cycle after iRST deassertion, oRESET[k] rises on edge LOCK_FILTER + (k+1)*STAGE_DLY.
- Released bits stay high until a re-sequence. The bit pattern is always thermometer-coded from bit 0.
- RUN: outputs stable; counter idle (or watchdog, if compiled in).
- Lock loss: iPLL_LOCKED = 0 in STAGE or RUN. Next edge: oRESET = 0, oREADY = 0, counter = 0, index = 0, state = WAIT_LOCK.
- Software request: iSW_RST_REQ = 1 in RUN. Next edge: oRESET = 0, oREADY = 0, counter = 0, state = HOLD.
- HOLD:
  - Counts SW_HOLD cycles, then enters WAIT_LOCK with counter = 0.
  - The lock filter is always re-applied.
  - Lock loss in HOLD is ignored; WAIT_LOCK handles it.
- iSW_RST_REQ is ignored in WAIT_LOCK, STAGE and HOLD.
- Priority in RUN: lock loss > software request > watchdog.
- No counter wrap: every compare is equality against a parameter below 2^CNT_W, and the counter is cleared on every state change.
- All outputs are registered; none is combinational from an input.

Optional Feature:
- Macro RESET_SEQ_WATCHDOG_EN.
- Defined:
  - In RUN, the counter increments each cycle; iWDT_KICK = 1 clears it.
  - When counter = WDT_CYCLES-1 without a kick: same action as a software request (enter HOLD), and oWDT_FIRED is set.
  - oWDT_FIRED clears only on iRST.
  - Kicks outside RUN are ignored.
- Not defined: iWDT_KICK is unused; oWDT_FIRED is tied 0; no watchdog logic is synthesized.

Test Plan:
Bench parameters for all scenarios: NUM_STAGES=3, STAGE_DLY=4, LOCK_FILTER=2, SW_HOLD=3, WDT_CYCLES=10.
- Power-up, lock high throughout, iRST released -> oRESET 001 at edge 6, 011 at edge 10, 111 at edge 14; oREADY=1 and oSTATE=2 at edge 14.
- Lock sequence 1,0,1,1,... after reset -> filter restarts on the low cycle; oRESET[0] rises 4 edges after the second consecutive high completes the filter (edge 8).
- Lock dropped for one cycle while oRESET=001 -> oRESET=000, oSTATE=0 next edge; full sequence repeats, 111 reached 14 edges after lock returns.
- iSW_RST_REQ pulse in RUN -> oRESET=000, oREADY=0, oSTATE=3 next edge; 3 HOLD cycles, 2 filter cycles, then 001/011/111 at 4-cycle spacing. A request pulsed during STAGE has no effect.
- iRST pulled low while oRESET=011 -> oRESET=000 and oREADY=0 asynchronously, before the next clock edge; normal sequence resumes after release.
- With RESET_SEQ_WATCHDOG_EN: no kick for 10 cycles in RUN -> HOLD entered and oWDT_FIRED=1, which stays set through re-sequencing. With a kick every 8 cycles -> no timeout.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES active-low domain resets in order, gated on a filtered PLL lock.
// Optional RUN-state watchdog is compiled in when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned STAGE_DLY   = 24'hFFFFFF,
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned SW_HOLD     = 256,
    parameter int unsigned WDT_CYCLES  = 24'hFFFFFF
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iPLL_LOCKED,
    input  logic                  iSW_RST_REQ,
    input  logic                  iWDT_KICK,
    output logic [NUM_STAGES-1:0] oRESET,
    output logic                  oREADY,
    output logic [1:0]            oSTATE,
    output logic                  oWDT_FIRED
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [NUM_STAGES-1:0] FIRST_BIT = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STAGE     = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  rdy_q, rdy_d;

`ifdef RESET_SEQ_WATCHDOG_EN
    logic                  wdt_q, wdt_d;
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) wdt_q <= 1'b0;
        else       wdt_q <= wdt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        rdy_d   = rdy_q;
`ifdef RESET_SEQ_WATCHDOG_EN
        wdt_d   = wdt_q;
`endif
        unique case (state_q)
            WAIT_LOCK: begin
                if (!iPLL_LOCKED) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                    state_d = STAGE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STAGE: begin
                if (!iPLL_LOCKED) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    rdy_d   = 1'b0;
                end else if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
                    // Shift keeps the released pattern thermometer-coded from bit 0.
                    rst_d = (rst_q << 1) | FIRST_BIT;
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        state_d = RUN;
                        rdy_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!iPLL_LOCKED) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    rdy_d   = 1'b0;
                end else if (iSW_RST_REQ) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    rdy_d   = 1'b0;
                end
`ifdef RESET_SEQ_WATCHDOG_EN
                else if (iWDT_KICK) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(WDT_CYCLES - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    rdy_d   = 1'b0;
                    wdt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (cnt_q == CNT_W'(SW_HOLD - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign oRESET = rst_q;
    assign oREADY = rdy_q;
    assign oSTATE = state_q;

`ifdef RESET_SEQ_WATCHDOG_EN
    assign oWDT_FIRED = wdt_q;
`else
    logic unused_wdt;
    assign unused_wdt = iWDT_KICK ^ WDT_CYCLES[0];
    assign oWDT_FIRED = 1'b0;
`endif

endmodule
